// File: rtl/e203_rst_req_pkg.sv
// Shared types and constants for the reset-request generator.
package e203_rst_req_pkg;

    localparam int CNT_W = 8;

    localparam int CAUSE_SW  = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_DBG = 2;
    localparam int CAUSE_POR = 3;

    localparam logic [3:0] CAUSE_RESET_VAL = 4'(1 << CAUSE_POR);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        HOLD      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/e203_rst_req_gen_if.sv
// Request/acknowledge bundle between the reset sources and the request generator.
// Handshake: requests are sampled on every rising clk edge with no ready;
// rst_done is a level acknowledge that is only observed while waiting for release.
interface e203_rst_req_gen_if;

    logic       test_mode;
    logic       sw_rst_req;
    logic       wdt_rst_req;
    logic       dbg_ndm_req;
    logic       rst_done;
    logic       cause_clr;
    logic       rst_req_n;
    logic       busy;
    logic       timeout;
    logic [3:0] cause;

    modport master (
        output test_mode, sw_rst_req, wdt_rst_req, dbg_ndm_req, rst_done, cause_clr,
        input  rst_req_n, busy, timeout, cause
    );

    modport slave (
        input  test_mode, sw_rst_req, wdt_rst_req, dbg_ndm_req, rst_done, cause_clr,
        output rst_req_n, busy, timeout, cause
    );

endinterface

// File: rtl/e203_rst_req_cnt.sv
// Loadable down-counter shared by the stretch and release-timeout phases.
module e203_rst_req_cnt
    import e203_rst_req_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/e203_rst_req_gen.sv
// Collects sw/wdt/dbg reset sources into a stretched active-low request,
// waits for the controller's release acknowledge and keeps sticky cause bits.
module e203_rst_req_gen
    import e203_rst_req_pkg::*;
#(
    parameter int STRETCH_CYC  = 16,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    e203_rst_req_gen_if.slave    bus,
    output state_t               dbg_state
);

    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(DONE_TIMEOUT - 1);

    state_t           state;
    state_t           state_n;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_zero;
    logic             to_flag;
    logic             req_any;
    logic             lvl_any;
    logic [3:0]       req_vec;
    logic             req_n_q;
    logic             busy_q;
    logic             timeout_q;
    logic [3:0]       cause_q;
    logic             req_n_n;
    logic             busy_n;
    logic             timeout_n;
    logic [3:0]       cause_n;

    e203_rst_req_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    assign req_any = bus.sw_rst_req | bus.wdt_rst_req | bus.dbg_ndm_req;
    assign lvl_any = bus.wdt_rst_req | bus.dbg_ndm_req;

    always_comb begin
        req_vec            = '0;
        req_vec[CAUSE_SW]  = bus.sw_rst_req;
        req_vec[CAUSE_WDT] = bus.wdt_rst_req;
        req_vec[CAUSE_DBG] = bus.dbg_ndm_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        to_flag  = 1'b0;
        if (bus.test_mode) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state_n  = ASSERT;
                        cnt_load = 1'b1;
                        cnt_val  = STRETCH_LD;
                    end
                end
                ASSERT: begin
                    if (cnt_zero) begin
                        state_n = HOLD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                HOLD: begin
                    if (!lvl_any) begin
                        state_n  = WAIT_DONE;
                        cnt_load = 1'b1;
                        cnt_val  = TIMEOUT_LD;
                    end
                end
                WAIT_DONE: begin
                    // A fresh request outranks a same-cycle release acknowledge.
                    if (req_any) begin
                        state_n  = ASSERT;
                        cnt_load = 1'b1;
                        cnt_val  = STRETCH_LD;
                    end else if (bus.rst_done) begin
                        state_n = IDLE;
                    end else if (cnt_zero) begin
                        state_n = IDLE;
                        to_flag = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        req_n_n   = !((state_n == ASSERT) || ((state_n == HOLD) && lvl_any));
        busy_n    = (state_n != IDLE);
        cause_n   = (bus.cause_clr ? 4'b0000 : cause_q) | (bus.test_mode ? 4'b0000 : req_vec);
        timeout_n = (bus.cause_clr ? 1'b0 : timeout_q) | to_flag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cause_q   <= CAUSE_RESET_VAL;
        end else begin
            req_n_q   <= req_n_n;
            busy_q    <= busy_n;
            timeout_q <= timeout_n;
            cause_q   <= cause_n;
        end
    end

    assign bus.rst_req_n = req_n_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;
    assign bus.cause     = cause_q;
    assign dbg_state     = state;

endmodule
